// File: rtl/tmp_code_decoder.sv
// ============================================================================
// Module   : tmp_code_decoder
// Purpose  : Decodes temperature-sensor charge phases into a windowed
//            sigma-delta HIGH-event count with a valid/ready result port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tmp_code_decoder #(
    parameter int WINDOW = 64,
    parameter int SETTLE = 8,
    parameter int CW     = $clog2(WINDOW) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          preChrg,
    input  logic          PA,
    input  logic          PB,
    input  logic          PC,
    input  logic          PD,
    output logic [CW-1:0] code,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          overrun,
    output logic          busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETTLE = 2'd1;
    localparam logic [1:0] c_ACCUM  = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [1:0] c_PAT_NONE = 2'd0;
    localparam logic [1:0] c_PAT_H    = 2'd1;
    localparam logic [1:0] c_PAT_L    = 2'd2;

    localparam logic [CW-1:0] c_SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] c_WINDOW_LAST = CW'(WINDOW - 1);

    logic          r_pre, r_pre_d, r_pa, r_pb, r_pc, r_pd;
    logic [1:0]    r_pat_prev;
    logic [1:0]    w_pat;
    logic          w_evt, w_is_h, w_pre_fall, w_pre_rise, w_xfer;
    logic [1:0]    r_state, w_state_nxt;
    logic [CW-1:0] r_evt_cnt, r_h_cnt;

    // Sample stage: every decision below looks only at the registered bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre      <= 1'b0;
            r_pre_d    <= 1'b0;
            r_pa       <= 1'b0;
            r_pb       <= 1'b0;
            r_pc       <= 1'b0;
            r_pd       <= 1'b0;
            r_pat_prev <= c_PAT_NONE;
        end else begin
            r_pre      <= preChrg;
            r_pre_d    <= r_pre;
            r_pa       <= PA;
            r_pb       <= PB;
            r_pc       <= PC;
            r_pd       <= PD;
            r_pat_prev <= w_pat;
        end
    end

    always_comb begin
        w_pat = c_PAT_NONE;
        if (r_pa && r_pb && !r_pc && !r_pd)
            w_pat = c_PAT_H;
        else if (r_pa && r_pc && !r_pb && !r_pd)
            w_pat = c_PAT_L;
    end

    assign w_evt      = (w_pat != c_PAT_NONE) && (w_pat != r_pat_prev);
    assign w_is_h     = (w_pat == c_PAT_H);
    assign w_pre_fall = r_pre_d && !r_pre;
    assign w_pre_rise = r_pre && !r_pre_d;
    assign w_xfer     = res_valid && res_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= c_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (en && w_pre_fall) w_state_nxt = c_SETTLE;
            c_SETTLE: if (w_evt && (r_evt_cnt == c_SETTLE_LAST)) w_state_nxt = c_ACCUM;
            c_ACCUM:  if (w_evt && (r_evt_cnt == c_WINDOW_LAST)) w_state_nxt = c_DONE;
            default:  w_state_nxt = c_ACCUM;
        endcase
        if (!en || (w_pre_rise && (r_state != c_IDLE)))
            w_state_nxt = c_IDLE;
    end

    always_comb begin
        busy = (r_state == c_SETTLE) || (r_state == c_ACCUM);
    end

    // An event seen during DONE opens the next window so none is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evt_cnt <= '0;
            r_h_cnt   <= '0;
        end else if ((w_state_nxt == c_IDLE) ||
                     ((r_state == c_SETTLE) && (w_state_nxt == c_ACCUM))) begin
            r_evt_cnt <= '0;
            r_h_cnt   <= '0;
        end else if (r_state == c_DONE) begin
            r_evt_cnt <= w_evt ? CW'(1) : '0;
            r_h_cnt   <= CW'(w_evt && w_is_h);
        end else if (w_evt) begin
            r_evt_cnt <= r_evt_cnt + CW'(1);
            r_h_cnt   <= r_h_cnt + CW'((r_state == c_ACCUM) && w_is_h);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code      <= '0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (r_state == c_DONE) begin
            if (!res_valid || res_ready) begin
                code      <= r_h_cnt;
                res_valid <= 1'b1;
                if (w_xfer && !en)
                    overrun <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (w_xfer) begin
            res_valid <= 1'b0;
            if (!en)
                overrun <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: doc/tmp_code_decoder.md
Name: tmp_code_decoder

Overview:
- Reader side of the temperature-sensor phase bus.
- Observes the controller's charge-phase outputs (PA..PD) and its precharge flag, classifies each charge event as HIGH or LOW, and accumulates a windowed sigma-delta count.
- Presents the result as a temperature code over a valid/ready handshake.
- Sits between the analog front-end controller and the readout/register block.

Parameters:
- WINDOW, 64: number of classified charge events per conversion; power of two, min 4.
- SETTLE, 8: number of charge events discarded after precharge ends, before accumulation.
- CW, $clog2(WINDOW)+1: code width; holds 0..WINDOW inclusive.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  decoder enable; low forces IDLE
- preChrg  input  1  precharge flag from controller
- PA  input  1  charge phase A
- PB  input  1  charge phase B
- PC  input  1  charge phase C
- PD  input  1  charge phase D
- code  output  CW  last accepted-window HIGH-event count
- res_valid  output  1  code valid
- res_ready  input  1  consumer accepts code
- overrun  output  1  sticky: a window completed while res_valid was high and unaccepted
- busy  output  1  state is SETTLE or ACCUM

Behaviour:
- Reset: clk and reset as decided (reset asynchronous, active-high; clock clk). All of the following are 0: state=IDLE, code, res_valid, overrun, busy, and the counters.
- Inputs are registered once (1-cycle sample stage). All detection uses the registered values.
- Pattern decode on the registered bus:
  - H = PA&PB&~PC&~PD
  - L = PA&PC&~PB&~PD
  - Any other combination is NONE. This includes OUTPUT (PB&PC&PD) and all-zero.
- Event: a cycle where the pattern is H or L and differs from the previous cycle's pattern.
  - Continuous H → L with no gap counts as two events.
  - Held patterns count once.
- States:
  - IDLE: waits for a falling edge of registered preChrg while en=1, then → SETTLE with evt_cnt=0.
  - SETTLE: counts events. When the SETTLE-th event occurs → ACCUM with evt_cnt=0 and h_cnt=0.
  - ACCUM: each event increments evt_cnt; H events also increment h_cnt. On the WINDOW-th event → DONE. That final event is included in h_cnt.
  - DONE (one cycle): result transfer (see below), then → ACCUM with counters cleared. This gives continuous conversion back-to-back.
- Result transfer in DONE:
  - If res_valid=0, or res_valid=1 with res_ready=1 in the same cycle: code <= h_cnt, res_valid <= 1.
  - Otherwise (res_valid=1, res_ready=0): the new result is dropped, code keeps the old value, overrun <= 1.
- Handshake:
  - Transfer occurs on a cycle with res_valid & res_ready. res_valid then clears the next cycle unless DONE reloads it that same cycle.
  - code is stable while res_valid=1.
  - overrun clears only on reset, or on a transfer when en=0.
- Abort: preChrg rising (registered) in SETTLE, ACCUM or DONE → IDLE. Counters cleared; res_valid and code are unaffected.
- en low: → IDLE next cycle, counters cleared; the output handshake still completes.
- Event in a DONE cycle: counted as the first event of the new window, so no event is lost.
- Latency: the last PA..PD edge of a window leads to res_valid high 3 cycles later (sample stage + event/count + DONE).
- Reset mid-operation: immediate return to reset values, regardless of state.
- Arithmetic:
  - h_cnt and evt_cnt are CW bits and never wrap, because WINDOW ≤ 2^(CW-1).
  - code = WINDOW is legal (all H).
- busy = (state==SETTLE)|(state==ACCUM).

Test Plan:
- Precharge pulse, then SETTLE=8 events, then 64 events alternating H,L with 2-cycle NONE gaps, res_ready=1 → code=32, res_valid pulses once, overrun=0.
- Window of 64 H events with H held 3 cycles each and NONE between → code=64. Then a window where H is held 10 cycles per event → still 1 event per hold; code=64.
- res_ready=0 through two full windows (first all L, second all H) → code=0 retained, overrun=1. Raise res_ready → transfer, res_valid=0 the next cycle.
- Raise preChrg mid-ACCUM after 20 events → state IDLE, busy=0, no result. The next precharge falling edge restarts SETTLE.
- Direct H→L→H transitions with no gap, 64 events → 64 events counted, code=32.
- Assert reset asynchronously between clock edges during ACCUM → all outputs 0 immediately, without waiting for a clock edge. Also drive OUTPUT pattern PA..PD=1111 → no event counted.
